// File: rtl/my_mem_pkg.sv
// my_mem_pkg: shared widths, store entry layout and parity helper
package my_mem_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W:0]   data;
    } mem_entry_t;

    function automatic logic parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/my_mem_cam.sv
// my_mem_cam: combinational associative lookup and lowest-free-slot search
module my_mem_cam
    import my_mem_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
    input  mem_entry_t        i_entries [NUM_ENTRIES],
    input  logic [ADDR_W-1:0] i_address,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_hit_idx,
    output logic              o_free_avail,
    output logic [IDX_W-1:0]  o_free_idx
);
    // Scan downwards so the lowest-index invalid entry is the one left in o_free_idx
    always_comb begin
        o_hit        = 1'b0;
        o_hit_idx    = '0;
        o_free_avail = 1'b0;
        o_free_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (i_entries[i].valid && i_entries[i].addr == i_address) begin
                o_hit     = 1'b1;
                o_hit_idx = IDX_W'(i);
            end
            if (!i_entries[i].valid) begin
                o_free_avail = 1'b1;
                o_free_idx   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/my_mem_responder.sv
// my_mem_responder: sparse byte store with parity, one-cycle read response, error counting
module my_mem_responder
    import my_mem_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W:0]   data_out,
    output logic              rd_valid,
    output logic              rd_miss,
    output logic              wr_drop,
    output logic              conflict,
    output logic [CNT_W-1:0]  error_count
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    mem_entry_t       r_entries [NUM_ENTRIES];
    logic [DATA_W:0]  r_data_out;
    logic             r_rd_valid;
    logic             r_rd_miss;
    logic             r_wr_drop;
    logic             r_conflict;
    logic [CNT_W-1:0] r_error_count;

    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_free_avail;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_wr_only;
    logic             w_rd_only;
    logic             w_conf;
    logic             w_drop;

    my_mem_cam #(.NUM_ENTRIES(NUM_ENTRIES)) u_cam (
        .i_entries   (r_entries),
        .i_address   (address),
        .o_hit       (w_hit),
        .o_hit_idx   (w_hit_idx),
        .o_free_avail(w_free_avail),
        .o_free_idx  (w_free_idx)
    );

    assign w_wr_only = write & ~read;
    assign w_rd_only = read & ~write;
    assign w_conf    = write & read;
    assign w_drop    = w_wr_only & ~w_hit & ~w_free_avail;

    // Store update: overwrite on hit, otherwise allocate the lowest free entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_entries[i] <= '0;
        end else if (w_wr_only) begin
            if (w_hit) r_entries[w_hit_idx].data <= {parity(data_in), data_in};
            else if (w_free_avail) r_entries[w_free_idx] <= '{1'b1, address, {parity(data_in), data_in}};
        end
    end

    // Registered read response, event pulses and saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out    <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_miss     <= 1'b0;
            r_wr_drop     <= 1'b0;
            r_conflict    <= 1'b0;
            r_error_count <= '0;
        end else begin
            r_rd_valid <= w_rd_only;
            r_rd_miss  <= w_rd_only & ~w_hit;
            r_wr_drop  <= w_drop;
            r_conflict <= w_conf;
            if (w_rd_only) r_data_out <= w_hit ? r_entries[w_hit_idx].data : '0;
            if ((w_conf | w_drop) && !(&r_error_count)) r_error_count <= r_error_count + CNT_W'(1);
        end
    end

    // A response pending when reset arrives is suppressed rather than presented
    assign rd_valid    = r_rd_valid & ~rst;
    assign rd_miss     = r_rd_miss & ~rst;
    assign data_out    = r_data_out;
    assign wr_drop     = r_wr_drop;
    assign conflict    = r_conflict;
    assign error_count = r_error_count;
endmodule

// File: tb/tb_my_mem_responder.sv
// tb_my_mem_responder: directed and random checks against an associative-array store model
module tb_my_mem_responder;
    logic        clk;
    logic        rst;
    logic        write;
    logic        read;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic [8:0]  data_out;
    logic        rd_valid;
    logic        rd_miss;
    logic        wr_drop;
    logic        conflict;
    logic [31:0] error_count;

    int total = 0;
    int bad = 0;

    logic [8:0]  mdl [logic [15:0]];
    logic [8:0]  m_dout;
    logic [31:0] m_err;

    my_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .read       (read),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .rd_miss    (rd_miss),
        .wr_drop    (wr_drop),
        .conflict   (conflict),
        .error_count(error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        write = 1'b0;
        read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl.delete();
        m_dout = '0;
        m_err = '0;
    endtask

    task automatic do_op(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
        logic ev, em, ed, ec;
        ev = 1'b0;
        em = 1'b0;
        ed = 1'b0;
        ec = 1'b0;
        write = w;
        read = r;
        address = a;
        data_in = d;
        if (w && r) begin
            ec = 1'b1;
            if (m_err != 32'hFFFF_FFFF) m_err++;
        end else if (w) begin
            if (mdl.exists(a) || mdl.num() < 16) mdl[a] = {^d, d};
            else begin
                ed = 1'b1;
                if (m_err != 32'hFFFF_FFFF) m_err++;
            end
        end else if (r) begin
            ev = 1'b1;
            em = !mdl.exists(a);
            m_dout = em ? 9'h000 : mdl[a];
        end
        @(posedge clk);
        #1;
        write = 1'b0;
        read = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        chk("rd_miss", 32'(rd_miss), 32'(em));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("wr_drop", 32'(wr_drop), 32'(ed));
        chk("conflict", 32'(conflict), 32'(ec));
        chk("error_count", error_count, m_err);
    endtask

    function automatic logic [15:0] fresh_addr(input logic [15:0] avoid);
        logic [15:0] a;
        do a = 16'($urandom); while (mdl.exists(a) || a == avoid);
        return a;
    endfunction

    initial begin
        logic [15:0] extra;
        logic [15:0] addrs [6];
        logic [15:0] keys [16];
        logic [15:0] tmp;
        int j;
        rst = 1'b0;
        write = 1'b0;
        read = 1'b0;
        address = '0;
        data_in = '0;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_miss", 32'(rd_miss), 0);
        chk("rst_wr_drop", 32'(wr_drop), 0);
        chk("rst_conflict", 32'(conflict), 0);
        chk("rst_error_count", error_count, 0);

        do_op(1, 0, 16'h1234, 8'hA5);
        do_op(0, 1, 16'h1234, 8'h00);
        chk("raw_data", 32'(data_out), 32'h0A5);

        do_reset();
        do_op(1, 0, 16'hBEEF, 8'h07);
        do_op(1, 0, 16'hBEEF, 8'h01);
        do_op(0, 1, 16'hBEEF, 8'h00);
        chk("overwrite_data", 32'(data_out), 32'h101);
        extra = 16'h5A5A;
        for (int i = 0; i < 15; i++) do_op(1, 0, fresh_addr(extra), 8'($urandom));
        chk("fill_no_drop_err", error_count, 0);
        do_op(1, 0, extra, 8'h3C);
        chk("full_drop", 32'(wr_drop), 1);
        chk("full_err", error_count, 1);
        do_op(0, 1, extra, 8'h00);
        chk("drop_read_miss", 32'(rd_miss), 1);
        chk("drop_read_data", 32'(data_out), 0);
        do_op(1, 0, 16'hBEEF, 8'hFF);
        chk("existing_no_drop", 32'(wr_drop), 0);
        do_op(0, 1, 16'hBEEF, 8'h00);

        do_op(1, 1, 16'hBEEF, 8'h11);
        do_op(1, 1, 16'hBEEF, 8'h22);
        chk("conflict_err", error_count, 3);
        do_op(0, 0, 16'h0000, 8'h00);
        chk("conflict_gone", 32'(conflict), 0);
        do_op(0, 1, 16'hBEEF, 8'h00);
        chk("conflict_store", 32'(data_out), 32'h0FF);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            addrs[i] = fresh_addr(16'h0000);
            do_op(1, 0, addrs[i], 8'($urandom));
        end
        for (int i = 5; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = addrs[i];
            addrs[i] = addrs[j];
            addrs[j] = tmp;
        end
        for (int i = 0; i < 6; i++) do_op(0, 1, addrs[i], 8'h00);
        chk("shuffle_err", error_count, 0);

        read = 1'b1;
        address = addrs[0];
        @(posedge clk);
        #1;
        read = 1'b0;
        rst = 1'b1;
        #1;
        chk("pre_rst_rd_valid", 32'(rd_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl.delete();
        m_dout = '0;
        m_err = '0;
        chk("post_rst_rd_valid", 32'(rd_valid), 0);
        do_op(0, 1, addrs[0], 8'h00);
        chk("post_rst_miss", 32'(rd_miss), 1);
        chk("post_rst_err", error_count, 0);

        do_reset();
        for (int i = 0; i < 16; i++) keys[i] = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            j = int'($urandom_range(99, 0));
            tmp = (i < 300) ? keys[$urandom_range(15, 0)] : 16'($urandom_range(40, 0));
            if (j < 40) do_op(1, 0, tmp, 8'($urandom));
            else if (j < 85) do_op(0, 1, tmp, 8'h00);
            else if (j < 92) do_op(1, 1, tmp, 8'($urandom));
            else do_op(0, 0, tmp, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
